// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus between the memory-access stage (master)
// and a variable-latency data memory (slave).
interface mem_access_stage_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                  input  mem_rdata, mem_ack);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                  output mem_rdata, mem_ack);
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: 1-cycle pass-through for ALU ops, req/ack access
// with upstream stall for loads/stores. Optional ack timeout under MA_TIMEOUT_EN.
module mem_access_stage #(
  parameter int                DATA_W         = 16,
  parameter int                ADDR_W         = 8,
  parameter int                REG_IDX_W      = 5,
  parameter int                CTRL_W         = 4,
  parameter logic [CTRL_W-1:0] LOAD_OP        = 4'b1100,
  parameter logic [CTRL_W-1:0] STORE_OP       = 4'b1110,
  parameter int                TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_ex,
  input  logic [CTRL_W-1:0]    control_ex,
  input  logic [DATA_W-1:0]    result_ex,
  input  logic [DATA_W-1:0]    reg_data_ex,
  input  logic [REG_IDX_W-1:0] dest_reg_index_ex,
  input  logic                 dest_reg_write_en_ex,
  output logic                 stall_ma,
  mem_access_stage_if.master   mem,
  output logic                 valid_ma,
  output logic [CTRL_W-1:0]    control_ma,
  output logic [DATA_W-1:0]    result_ma,
  output logic [DATA_W-1:0]    data_ma,
  output logic [REG_IDX_W-1:0] dest_reg_index_ma,
  output logic                 dest_reg_write_en_ma,
  output logic                 err_ma
);

  typedef enum logic {IDLE, REQ} state_t;
  state_t state;

  logic [CTRL_W-1:0]    h_ctrl;
  logic [DATA_W-1:0]    h_result;
  logic [REG_IDX_W-1:0] h_dest;
  logic                 h_wen;

  logic is_mem_ex, held_load, timeout;
  assign is_mem_ex = (control_ex == LOAD_OP) || (control_ex == STORE_OP);
  assign held_load = (h_ctrl == LOAD_OP);
  assign stall_ma  = (state == REQ);

`ifdef MA_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] wait_cnt;
  assign timeout = (wait_cnt == CNT_LAST);
`else
  assign timeout = 1'b0;
  assign err_ma  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= IDLE;
      mem.mem_req          <= 1'b0;
      mem.mem_we           <= 1'b0;
      mem.mem_addr         <= '0;
      mem.mem_wdata        <= '0;
      valid_ma             <= 1'b0;
      control_ma           <= '0;
      result_ma            <= '0;
      data_ma              <= '0;
      dest_reg_index_ma    <= '0;
      dest_reg_write_en_ma <= 1'b0;
      h_ctrl               <= '0;
      h_result             <= '0;
      h_dest               <= '0;
      h_wen                <= 1'b0;
`ifdef MA_TIMEOUT_EN
      wait_cnt             <= '0;
      err_ma               <= 1'b0;
`endif
    end else begin
`ifdef MA_TIMEOUT_EN
      err_ma <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (!valid_ex) begin
            valid_ma             <= 1'b0;
            dest_reg_write_en_ma <= 1'b0;
          end else if (is_mem_ex) begin
            h_ctrl               <= control_ex;
            h_result             <= result_ex;
            h_dest               <= dest_reg_index_ex;
            h_wen                <= dest_reg_write_en_ex;
            mem.mem_req          <= 1'b1;
            mem.mem_we           <= (control_ex == STORE_OP);
            mem.mem_addr         <= result_ex[ADDR_W-1:0];
            mem.mem_wdata        <= reg_data_ex;
            valid_ma             <= 1'b0;
            dest_reg_write_en_ma <= 1'b0;
            state                <= REQ;
`ifdef MA_TIMEOUT_EN
            wait_cnt             <= '0;
`endif
          end else begin
            valid_ma             <= 1'b1;
            control_ma           <= control_ex;
            result_ma            <= result_ex;
            data_ma              <= '0;
            dest_reg_index_ma    <= dest_reg_index_ex;
            dest_reg_write_en_ma <= dest_reg_write_en_ex;
          end
        end
        REQ: begin
          // Ack and timeout share the retire path; ack takes priority.
          if (mem.mem_ack || timeout) begin
            state                <= IDLE;
            mem.mem_req          <= 1'b0;
            mem.mem_we           <= 1'b0;
            valid_ma             <= 1'b1;
            control_ma           <= h_ctrl;
            result_ma            <= h_result;
            dest_reg_index_ma    <= h_dest;
            data_ma              <= (mem.mem_ack && held_load) ? mem.mem_rdata : '0;
            dest_reg_write_en_ma <= mem.mem_ack && held_load && h_wen;
`ifdef MA_TIMEOUT_EN
            err_ma               <= !mem.mem_ack;
`endif
          end else begin
            valid_ma             <= 1'b0;
            dest_reg_write_en_ma <= 1'b0;
`ifdef MA_TIMEOUT_EN
            wait_cnt             <= wait_cnt + 1'b1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed literal checks plus a randomized run
// against a transaction-level model of the stage.
module tb_mem_access_stage;
  localparam int DW = 16, AW = 8, RW = 5, CW = 4, TO = 4;
  localparam logic [CW-1:0] LD = 4'b1100, ST = 4'b1110;

  logic clk = 1'b0, reset;
  logic valid_ex, dest_reg_write_en_ex;
  logic [CW-1:0] control_ex;
  logic [DW-1:0] result_ex, reg_data_ex;
  logic [RW-1:0] dest_reg_index_ex;
  logic stall_ma, valid_ma, dest_reg_write_en_ma, err_ma;
  logic [CW-1:0] control_ma;
  logic [DW-1:0] result_ma, data_ma;
  logic [RW-1:0] dest_reg_index_ma;

  mem_access_stage_if #(.ADDR_W(AW), .DATA_W(DW)) mem ();

  mem_access_stage #(
    .DATA_W(DW), .ADDR_W(AW), .REG_IDX_W(RW), .CTRL_W(CW),
    .LOAD_OP(LD), .STORE_OP(ST), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .valid_ex(valid_ex), .control_ex(control_ex),
    .result_ex(result_ex), .reg_data_ex(reg_data_ex),
    .dest_reg_index_ex(dest_reg_index_ex), .dest_reg_write_en_ex(dest_reg_write_en_ex),
    .stall_ma(stall_ma), .mem(mem), .valid_ma(valid_ma), .control_ma(control_ma),
    .result_ma(result_ma), .data_ma(data_ma), .dest_reg_index_ma(dest_reg_index_ma),
    .dest_reg_write_en_ma(dest_reg_write_en_ma), .err_ma(err_ma)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] res;
    logic [DW-1:0] rd;
    logic [RW-1:0] dst;
    logic          wen;
  } op_t;

  int n_cmp = 0, n_bad = 0;

  // Model: one outstanding memory transaction plus the expected output view.
  bit            m_busy;
  op_t           m_op;
  int            m_wait;
  logic          e_req, e_we, e_valid, e_wen, e_err;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_res, e_data;
  logic [CW-1:0] e_ctrl;
  logic [RW-1:0] e_dst;

`ifdef MA_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  function automatic op_t mk(logic [CW-1:0] c, logic [DW-1:0] r, logic [DW-1:0] d,
                             logic [RW-1:0] dst, logic w);
    op_t o;
    o.ctrl = c; o.res = r; o.rd = d; o.dst = dst; o.wen = w;
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_wait = 0;
    e_req = 0; e_we = 0; e_valid = 0; e_wen = 0; e_err = 0;
    e_addr = '0; e_wdata = '0; e_res = '0; e_data = '0; e_ctrl = '0; e_dst = '0;
  endtask

  task automatic retire(input logic [DW-1:0] rdata, input bit timed_out);
    m_busy  = 0;
    e_req   = 0; e_we = 0;
    e_valid = 1;
    e_ctrl  = m_op.ctrl; e_res = m_op.res; e_dst = m_op.dst;
    e_data  = (!timed_out && m_op.ctrl == LD) ? rdata : '0;
    e_wen   = !timed_out && m_op.ctrl == LD && m_op.wen;
    e_err   = timed_out;
  endtask

  task automatic model_edge(input logic vin, input op_t in, input logic ack,
                            input logic [DW-1:0] rdata);
    e_err = 0;
    if (m_busy) begin
      if (ack) retire(rdata, 0);
      else if (TO_EN && m_wait == TO - 1) retire('0, 1);
      else begin m_wait++; e_valid = 0; e_wen = 0; end
    end else if (vin && (in.ctrl == LD || in.ctrl == ST)) begin
      m_busy = 1; m_op = in; m_wait = 0;
      e_req = 1; e_we = (in.ctrl == ST); e_addr = in.res[AW-1:0]; e_wdata = in.rd;
      e_valid = 0; e_wen = 0;
    end else if (vin) begin
      e_valid = 1; e_ctrl = in.ctrl; e_res = in.res; e_data = '0;
      e_dst = in.dst; e_wen = in.wen;
    end else begin
      e_valid = 0; e_wen = 0;
    end
  endtask

  task automatic check_all();
    chk("stall_ma", stall_ma, m_busy);
    chk("mem_req", mem.mem_req, e_req);
    chk("mem_we", mem.mem_we, e_we);
    chk("mem_addr", mem.mem_addr, e_addr);
    if (e_req && e_we) chk("mem_wdata", mem.mem_wdata, e_wdata);
    chk("valid_ma", valid_ma, e_valid);
    chk("wen_ma", dest_reg_write_en_ma, e_wen);
    chk("err_ma", err_ma, e_err);
    chk("control_ma", control_ma, e_ctrl);
    chk("result_ma", result_ma, e_res);
    chk("data_ma", data_ma, e_data);
    chk("dest_ma", dest_reg_index_ma, e_dst);
  endtask

  task automatic step(input logic vin, input op_t op, input logic ack, input logic [DW-1:0] rd);
    valid_ex = vin; control_ex = op.ctrl; result_ex = op.res; reg_data_ex = op.rd;
    dest_reg_index_ex = op.dst; dest_reg_write_en_ex = op.wen;
    mem.mem_ack = ack; mem.mem_rdata = rd;
    model_edge(vin, op, ack, rd);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    reset = 1; valid_ex = 0; mem.mem_ack = 0;
    @(negedge clk);
    model_reset();
    check_all();
    reset = 0;
  endtask

  initial begin
    op_t nop, ld, st, alu, cur;
    bit  cur_v, take_new;
    int  w, age;
    logic ack;
    nop = mk(4'h0, 16'h0, 16'h0, 5'd0, 1'b0);
    reset = 1; valid_ex = 0; control_ex = '0; result_ex = '0; reg_data_ex = '0;
    dest_reg_index_ex = '0; dest_reg_write_en_ex = 0; mem.mem_ack = 0; mem.mem_rdata = '0;
    @(negedge clk);
    do_reset();
    chk("rst_req", mem.mem_req, 0);
    chk("rst_valid", valid_ma, 0);
    chk("rst_result", result_ma, 0);

    // Non-memory op: one-cycle pass-through, no stall
    alu = mk(4'b0001, 16'h1234, 16'h0, 5'd3, 1'b1);
    step(1, alu, 0, '0);
    chk("alu_valid", valid_ma, 1);
    chk("alu_result", result_ma, 16'h1234);
    chk("alu_dest", dest_reg_index_ma, 3);
    chk("alu_stall", stall_ma, 0);
    step(0, nop, 0, '0);

    // Zero-wait load
    ld = mk(LD, 16'h0042, 16'h0, 5'd7, 1'b1);
    step(1, ld, 0, '0);
    chk("ld_req", mem.mem_req, 1);
    chk("ld_we", mem.mem_we, 0);
    chk("ld_addr", mem.mem_addr, 8'h42);
    chk("ld_bubble", valid_ma, 0);
    step(1, ld, 1, 16'hBEEF);
    chk("ld_req_drop", mem.mem_req, 0);
    chk("ld_valid", valid_ma, 1);
    chk("ld_data", data_ma, 16'hBEEF);
    chk("ld_wen", dest_reg_write_en_ma, 1);
    step(0, nop, 0, '0);

    // 3-wait store: request held stable for 4 cycles
    st = mk(ST, 16'h0010, 16'hA5A5, 5'd9, 1'b1);
    step(1, st, 0, '0);
    for (int i = 0; i < 3; i++) begin
      chk("st_req", mem.mem_req, 1);
      chk("st_wdata", mem.mem_wdata, 16'hA5A5);
      chk("st_stall", stall_ma, 1);
      step(1, st, 0, '0);
    end
    chk("st_req_last", mem.mem_req, 1);
    step(1, st, 1, 16'h5555);
    chk("st_valid", valid_ma, 1);
    chk("st_wen", dest_reg_write_en_ma, 0);
    chk("st_data", data_ma, 0);

    // Load then ALU op back-to-back
    step(1, ld, 0, '0);
    step(1, ld, 1, 16'h1111);
    chk("b2b_ld_valid", valid_ma, 1);
    step(1, alu, 0, '0);
    chk("b2b_alu_valid", valid_ma, 1);
    chk("b2b_alu_result", result_ma, 16'h1234);
    step(0, nop, 0, '0);

    // Reset two cycles into a wait, then a late ack
    step(1, ld, 0, '0);
    step(1, ld, 0, '0);
    step(1, ld, 0, '0);
    do_reset();
    chk("rstreq_req", mem.mem_req, 0);
    chk("rstreq_stall", stall_ma, 0);
    chk("rstreq_valid", valid_ma, 0);
    step(0, nop, 1, 16'h7777);
    chk("late_ack_req", mem.mem_req, 0);
    chk("late_ack_valid", valid_ma, 0);

`ifdef MA_TIMEOUT_EN
    step(1, ld, 0, '0);
    for (int i = 0; i < 3; i++) begin
      chk("to_req", mem.mem_req, 1);
      step(1, ld, 0, '0);
    end
    chk("to_req_drop", mem.mem_req, 0);
    chk("to_valid", valid_ma, 1);
    chk("to_err", err_ma, 1);
    chk("to_wen", dest_reg_write_en_ma, 0);
    step(0, nop, 0, '0);
    chk("to_err_clear", err_ma, 0);
`endif

    // Randomized run: held instruction replaced only once the stage accepted it
    take_new = 1; cur = nop; cur_v = 0; w = 0; age = 0;
    for (int c = 0; c < 2000; c++) begin
      if (take_new) begin
        int r;
        r = $urandom_range(0, 2);
        cur_v = ($urandom_range(0, 3) != 0);
        cur = mk(r == 0 ? LD : (r == 1 ? ST : CW'($urandom_range(0, 15))),
                 DW'($urandom), DW'($urandom), RW'($urandom), 1'($urandom));
      end
      if (m_busy) begin
        ack = (age >= w);
        age++;
      end else begin
        ack = ($urandom_range(0, 3) == 0);
        if (cur_v && (cur.ctrl == LD || cur.ctrl == ST)) begin
          w = $urandom_range(0, 5); age = 0;
        end
      end
      take_new = !m_busy;
      step(cur_v, cur, ack, DW'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
